// File: rtl/bus_map_pkg.sv
// Shared definitions for the CPU-side memory bus: region map, FSM states, decode.
package bus_map_pkg;

  localparam logic [3:0] DEF_ROM_REGION  = 4'h0;
  localparam logic [3:0] DEF_GPIO_REGION = 4'h1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RGN_ROM  = 2'd0,
    RGN_GPIO = 2'd1,
    RGN_NONE = 2'd2
  } region_t;

  function automatic region_t decode_region(input logic [3:0] nib,
                                            input logic [3:0] rom_rgn,
                                            input logic [3:0] gpio_rgn);
    if (nib == rom_rgn)       return RGN_ROM;
    else if (nib == gpio_rgn) return RGN_GPIO;
    else                      return RGN_NONE;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin pick; the pointer remembers the most recent owner.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       owner,
  output logic [1:0] grant
);

  logic r_last;

  // Reset to "M1 last" so M0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_last <= 1'b1;
    else if (advance) r_last <= owner;
  end

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = r_last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the ROM/GPIO bus between instruction fetch (M0) and data (M1) masters;
// each transaction runs IDLE -> BUS -> ACK.
module mem_bus_arbiter
  import bus_map_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter logic [3:0]  ROM_REGION  = DEF_ROM_REGION,
  parameter logic [3:0]  GPIO_REGION = DEF_GPIO_REGION
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_wen,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_wen,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_gpio_wen,
  input  logic [DATA_W-1:0] s_rom_rdata,
  input  logic [DATA_W-1:0] s_gpio_rdata,
  output logic              bus_err
);

  state_t              r_state;
  logic                r_owner;
  logic                r_wen;
  region_t             r_region;
  logic [ADDR_W-1:0]   r_s_addr;
  logic [DATA_W-1:0]   r_s_wdata;
  logic                r_gpio_wen;
  logic                r_m0_ack;
  logic                r_m1_ack;
  logic                r_bus_err;

  logic [1:0]          w_grant;
  logic                w_sel;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_wen;
  region_t             w_region;
  logic [DATA_W-1:0]   w_rdata;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst     (reset),
    .req     ({m1_req, m0_req}),
    .advance (r_state == ACK),
    .owner   (r_owner),
    .grant   (w_grant)
  );

  assign w_sel    = w_grant[1];
  assign w_addr   = w_sel ? m1_addr  : m0_addr;
  assign w_wdata  = w_sel ? m1_wdata : m0_wdata;
  assign w_wen    = w_sel ? m1_wen   : m0_wen;
  assign w_region = decode_region(w_addr[ADDR_W-1 -: 4], ROM_REGION, GPIO_REGION);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_owner    <= 1'b0;
      r_wen      <= 1'b0;
      r_region   <= RGN_NONE;
      r_s_addr   <= '0;
      r_s_wdata  <= '0;
      r_gpio_wen <= 1'b0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_m0_ack  <= 1'b0;
          r_m1_ack  <= 1'b0;
          r_bus_err <= 1'b0;
          if (|w_grant) begin
            r_owner    <= w_sel;
            r_wen      <= w_wen;
            r_region   <= w_region;
            r_s_addr   <= w_addr;
            r_s_wdata  <= w_wdata;
            r_gpio_wen <= w_wen && (w_region == RGN_GPIO);
            r_state    <= BUS;
          end
        end
        BUS: begin
          r_gpio_wen <= 1'b0;
          r_m0_ack   <= ~r_owner;
          r_m1_ack   <= r_owner;
          r_bus_err  <= (r_region == RGN_NONE) || (r_region == RGN_ROM && r_wen);
          r_state    <= ACK;
        end
        ACK: begin
          r_m0_ack  <= 1'b0;
          r_m1_ack  <= 1'b0;
          r_bus_err <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          r_gpio_wen <= 1'b0;
          r_m0_ack   <= 1'b0;
          r_m1_ack   <= 1'b0;
          r_bus_err  <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  // ROM data only arrives during ACK, so the read mux stays combinational behind the registered ack.
  always_comb begin
    w_rdata = '0;
    if (!r_wen) begin
      case (r_region)
        RGN_ROM:  w_rdata = s_rom_rdata;
        RGN_GPIO: w_rdata = s_gpio_rdata;
        default:  w_rdata = '0;
      endcase
    end
  end

  assign m0_ack     = r_m0_ack;
  assign m1_ack     = r_m1_ack;
  assign m0_rdata   = r_m0_ack ? w_rdata : '0;
  assign m1_rdata   = r_m1_ack ? w_rdata : '0;
  assign s_addr     = r_s_addr;
  assign s_wdata    = r_s_wdata;
  assign s_gpio_wen = r_gpio_wen;
  assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter with behavioural ROM/GPIO slaves and an ack scoreboard.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic        m0_wen = 1'b0, m1_wen = 1'b0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] s_addr, s_wdata;
  logic        s_gpio_wen;
  logic [31:0] s_rom_rdata = '0;
  logic [31:0] s_gpio_rdata;
  logic        bus_err;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .ROM_REGION(4'h0), .GPIO_REGION(4'h1)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wen(m1_wen), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_gpio_wen(s_gpio_wen),
    .s_rom_rdata(s_rom_rdata), .s_gpio_rdata(s_gpio_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Slave models: synchronous ROM, four GPIO words with combinational readback.
  logic [31:0] rom [256];
  logic [31:0] gpio_regs [4];
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'hC0DE_0000 + i;
    rom[2] = 32'h1234_5678;
    for (int i = 0; i < 4; i++) gpio_regs[i] = '0;
  end
  always @(posedge clk) begin
    s_rom_rdata <= rom[s_addr[9:2]];
    if (s_gpio_wen) gpio_regs[s_addr[3:2]] <= s_wdata;
  end
  assign s_gpio_rdata = gpio_regs[s_addr[3:2]];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int gwen_cnt = 0;
  logic [31:0] gwen_data = '0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          m;
    logic [31:0] rdata;
    bit          err;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    bit          m;
    logic [31:0] addr;
    bit          wen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          gwen;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Scoreboard: every ack pops one expected completion.
  always @(negedge clk) begin
    if (s_gpio_wen) begin
      gwen_cnt++;
      gwen_data = s_wdata;
    end
    if (m0_ack && m1_ack) check("one_ack", 32'd1, 32'd0);
    if (bus_err && !(m0_ack || m1_ack)) check("err_without_ack", 32'd1, 32'd0);
    if (m0_ack || m1_ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {31'd0, m1_ack}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ack_owner", {31'd0, m1_ack}, {31'd0, e.m});
        check("rdata", e.m ? m1_rdata : m0_rdata, e.rdata);
        check("idle_rdata", e.m ? m0_rdata : m1_rdata, 32'd0);
        check("bus_err", {31'd0, bus_err}, {31'd0, e.err});
      end
    end
  end

  task automatic set_req(input bit m, input logic [31:0] a, input bit w, input logic [31:0] d, input bit v);
    if (m) begin m1_req = v; m1_addr = a; m1_wen = w; m1_wdata = d; end
    else   begin m0_req = v; m0_addr = a; m0_wen = w; m0_wdata = d; end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(m0_ack || m1_ack) && n < 10);
    if (!(m0_ack || m1_ack)) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_txn(input vec_t v);
    int n;
    int g0;
    exp_t e;
    e.m = v.m; e.rdata = v.rdata; e.err = v.err;
    exp_q.push_back(e);
    g0 = gwen_cnt;
    @(negedge clk);
    set_req(v.m, v.addr, v.wen, v.wdata, 1'b1);
    wait_ack(n);
    check("latency", n, 32'd2);
    set_req(v.m, v.addr, v.wen, v.wdata, 1'b0);
    @(posedge clk); #1;
    check("gpio_wen_cycles", gwen_cnt - g0, v.gwen);
    if (v.gwen != 0) check("s_wdata", gwen_data, v.wdata);
  endtask

  vec_t vecs[10];
  int n, last;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0008, 1'b0, 32'h0,         32'h1234_5678, 1'b0, 0};
    vecs[1] = '{1'b1, 32'h1000_0000, 1'b1, 32'h0000_00A5, 32'h0,         1'b0, 1};
    vecs[2] = '{1'b1, 32'h1000_0000, 1'b0, 32'h0,         32'h0000_00A5, 1'b0, 0};
    vecs[3] = '{1'b0, 32'h0000_0004, 1'b1, 32'hFFFF_0000, 32'h0,         1'b1, 0};
    vecs[4] = '{1'b0, 32'h2000_0000, 1'b0, 32'h0,         32'h0,         1'b1, 0};
    vecs[5] = '{1'b1, 32'h0000_0014, 1'b0, 32'h0,         32'hC0DE_0005, 1'b0, 0};
    vecs[6] = '{1'b0, 32'h1000_0004, 1'b1, 32'hDEAD_BEEF, 32'h0,         1'b0, 1};
    vecs[7] = '{1'b0, 32'h1000_0004, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0, 0};
    vecs[8] = '{1'b1, 32'h1000_0000, 1'b0, 32'h0,         32'h0000_00A5, 1'b0, 0};
    vecs[9] = '{1'b1, 32'hF000_0000, 1'b0, 32'h0,         32'h0,         1'b1, 0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
    check("rst_s_addr", s_addr, 32'd0);
    check("rst_s_wdata", s_wdata, 32'd0);
    check("rst_gpio_wen", {31'd0, s_gpio_wen}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) do_txn(vecs[i]);

    // Continuous contention: grants alternate starting from M0 (M0 granted last by vecs[7]? no: vecs[9] was M1).
    for (int k = 0; k < 6; k++) begin
      exp_t e;
      e.m = k[0]; e.rdata = k[0] ? 32'h0000_00A5 : 32'h1234_5678; e.err = 1'b0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    set_req(1'b0, 32'h0000_0008, 1'b0, 32'h0, 1'b1);
    set_req(1'b1, 32'h1000_0000, 1'b0, 32'h0, 1'b1);
    last = 0;
    for (int k = 0; k < 6; k++) begin
      wait_ack(n);
      if (k > 0) check("ack_spacing", cyc - last, 32'd3);
      last = cyc;
      if (k == 5) begin m0_req = 1'b0; m1_req = 1'b1 ^ 1'b1; end
    end
    @(posedge clk); #1;

    // Reset during BUS of an M1 GPIO write.
    @(negedge clk);
    set_req(1'b1, 32'h1000_0000, 1'b1, 32'h0000_005A, 1'b1);
    @(posedge clk); #1;
    check("bus_gpio_wen", {31'd0, s_gpio_wen}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("async_gpio_wen", {31'd0, s_gpio_wen}, 32'd0);
    check("async_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
    check("async_s_addr", s_addr, 32'd0);
    @(negedge clk); m1_req = 1'b0;
    @(negedge clk); reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abandoned_write", gpio_regs[0], 32'h0000_00A5);

    // First tie after reset goes to M0.
    begin
      exp_t e;
      e.m = 1'b0; e.rdata = 32'h1234_5678; e.err = 1'b0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    set_req(1'b0, 32'h0000_0008, 1'b0, 32'h0, 1'b1);
    set_req(1'b1, 32'h1000_0000, 1'b0, 32'h0, 1'b1);
    wait_ack(n);
    check("tie_after_reset", {31'd0, m0_ack}, 32'd1);
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;

    // M0 drops req during BUS; ack still arrives.
    begin
      exp_t e;
      e.m = 1'b0; e.rdata = 32'hC0DE_0001; e.err = 1'b0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    set_req(1'b0, 32'h0000_0004, 1'b0, 32'h0, 1'b1);
    @(posedge clk); #1;
    m0_req = 1'b0;
    wait_ack(n);
    check("dropped_req_latency", n, 32'd1);
    @(posedge clk); #1;
    do_txn(vecs[0]);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
